// File: rtl/instruction_sequencer.sv
// Instruction-cycle sequencer: steps the 8-phase cycle, latches OPR/OPA from the bus
// and decodes the accumulator/register/carry subset into single-clock datapath strobes.
module instruction_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data,
  output logic [2:0] phase,
  output logic       sync,
  output logic       second_word,
  output logic       clear_carry,
  output logic       write_carry,
  output logic       clear_accumulator,
  output logic       write_accumulator,
  output logic       write_register,
  output logic [3:0] inst_operand,
  output logic [2:0] acc_input_sel,
  output logic [1:0] reg_input_sel,
  output logic [2:0] alu_op,
  output logic [1:0] alu_in0_sel,
  output logic [1:0] alu_in1_sel,
  output logic [1:0] alu_cin_sel
);

  typedef enum logic [2:0] {
    A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
    M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
  } phase_t;

  localparam logic [2:0] ACC_REG = 3'd0, ACC_ALU = 3'd1, ACC_IMM = 3'd2,
                         ACC_CARRY = 3'd3, ACC_CARRY2 = 3'd4;
  localparam logic [1:0] REG_ACC = 2'd0, REG_ALU = 2'd1, REG_DATA = 2'd2;
  localparam logic [1:0] IN0_ACC = 2'd0, IN0_REG = 2'd1;
  localparam logic [1:0] IN1_REG = 2'd0, IN1_NOT_REG = 2'd1, IN1_ZERO = 2'd2;
  localparam logic [1:0] CIN_CARRY = 2'd1, CIN_NOT_CARRY = 2'd2, CIN_ONE = 2'd3;

  phase_t     state, state_next;
  logic [3:0] opr, opa;
  logic       is_fim;

  assign is_fim = (opr == 4'h2) && !opa[0];

  always_ff @(posedge clock) begin
    if (reset) state <= A1;
    else       state <= state_next;
  end

  always_comb begin
    state_next = phase_t'(state + 3'd1);
  end

  // During a FIM second word the bus carries the data byte, so opr/opa must hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      opr         <= 4'h0;
      opa         <= 4'h0;
      second_word <= 1'b0;
    end else begin
      if (state == M1 && !second_word) opr <= data;
      if (state == M2 && !second_word) opa <= data;
      if (state == X3) second_word <= !second_word && is_fim;
    end
  end

  assign phase  = state;
  assign sync   = (state == X3);
  assign alu_op = 3'd0;

  always_comb begin
    clear_carry       = 1'b0;
    write_carry       = 1'b0;
    clear_accumulator = 1'b0;
    write_accumulator = 1'b0;
    write_register    = 1'b0;
    inst_operand      = opa;
    acc_input_sel     = ACC_REG;
    reg_input_sel     = REG_ACC;
    alu_in0_sel       = IN0_ACC;
    alu_in1_sel       = IN1_REG;
    alu_cin_sel       = 2'd0;
    if (second_word) begin
      // Data word goes straight into the pair: high nibble to R in M1, low nibble to R|1 in M2.
      if (state == M1 || state == M2) begin
        write_register = 1'b1;
        reg_input_sel  = REG_DATA;
        inst_operand   = {opa[3:1], state == M2};
      end
    end else if (state == X1) begin
      case (opr)
        4'h6: begin
          write_register = 1'b1;
          reg_input_sel  = REG_ALU;
          alu_in0_sel    = IN0_REG;
          alu_in1_sel    = IN1_ZERO;
          alu_cin_sel    = CIN_ONE;
        end
        4'h8, 4'h9: begin
          write_accumulator = 1'b1;
          write_carry       = 1'b1;
          acc_input_sel     = ACC_ALU;
          alu_in0_sel       = IN0_ACC;
          alu_in1_sel       = (opr == 4'h9) ? IN1_NOT_REG : IN1_REG;
          alu_cin_sel       = (opr == 4'h9) ? CIN_NOT_CARRY : CIN_CARRY;
        end
        4'hA: begin
          write_accumulator = 1'b1;
          acc_input_sel     = ACC_REG;
        end
        4'hB: begin
          write_accumulator = 1'b1;
          write_register    = 1'b1;
          acc_input_sel     = ACC_REG;
          reg_input_sel     = REG_ACC;
        end
        4'hD: begin
          write_accumulator = 1'b1;
          acc_input_sel     = ACC_IMM;
        end
        4'hF: begin
          case (opa)
            4'h0: begin
              clear_accumulator = 1'b1;
              clear_carry       = 1'b1;
            end
            4'h1: clear_carry = 1'b1;
            4'h2: begin
              write_accumulator = 1'b1;
              write_carry       = 1'b1;
              acc_input_sel     = ACC_ALU;
              alu_in0_sel       = IN0_ACC;
              alu_in1_sel       = IN1_ZERO;
              alu_cin_sel       = CIN_ONE;
            end
            4'h7: begin
              write_accumulator = 1'b1;
              acc_input_sel     = ACC_CARRY;
              clear_carry       = 1'b1;
            end
            4'h9: begin
              write_accumulator = 1'b1;
              acc_input_sel     = ACC_CARRY2;
              clear_carry       = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
